// File: rtl/seg_pkg.sv
// Shared 7-segment types, state encoding and hex patterns for the display
// path; used by both the hex decoder and the scan driver.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}.
    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = SEG_OFF;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Loadable down-counter that parks at zero; tc flags the last cycle of the
// loaded interval.
module seg_scan_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] count_r;

    // Count register: load wins over decrement, holds once it reaches zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {WIDTH{1'b0}}) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan driver for a common-anode 7-segment display with
// per-slot blanking and a once-per-frame input snapshot.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int DRIVE_CYCLES   = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [6:0]            segments_in [NUM_DIGITS],
    input  logic [NUM_DIGITS-1:0] dp_in,
    input  logic [NUM_DIGITS-1:0] digit_en,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
    output logic                  frame_tick
);

    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int MAXC = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] DRV_LOAD = CW'(DRIVE_CYCLES - 1);
    localparam logic [CW-1:0] BLK_LOAD = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    // With no blank phase a new slot starts straight in DRIVE.
    localparam scan_state_t   SLOT_STATE = (BLANK_CYCLES > 0) ? BLANK : DRIVE;
    localparam logic [CW-1:0] SLOT_LOAD  = (BLANK_CYCLES > 0) ? BLK_LOAD : DRV_LOAD;
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF =
        (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    scan_state_t           state_r, state_s;
    logic [IW-1:0]         idx_r, idx_s;
    logic                  frame_start_s;
    logic                  load_s;
    logic [CW-1:0]         load_val_s;
    logic                  tc_s;

    seg_t                  seg_sh_r [NUM_DIGITS];
    seg_t                  seg_sh_s [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dp_sh_r, dp_sh_s;
    logic [NUM_DIGITS-1:0] en_sh_r, en_sh_s;
    logic [NUM_DIGITS-1:0] onehot_s;

    seg_t                  seg_r, seg_s;
    logic                  dp_r, dp_s;
    logic [NUM_DIGITS-1:0] sel_r, sel_s;
    logic                  tick_r;

    seg_scan_timer #(.WIDTH(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .load_val (load_val_s),
        .tc       (tc_s)
    );

    // Next-state, slot index and timer reload decisions.
    always_comb begin
        state_s       = state_r;
        idx_s         = idx_r;
        frame_start_s = 1'b0;
        load_s        = 1'b0;
        load_val_s    = {CW{1'b0}};
        if (!enable) begin
            state_s    = IDLE;
            idx_s      = {IW{1'b0}};
            load_s     = 1'b1;
            load_val_s = {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    frame_start_s = 1'b1;
                    idx_s         = {IW{1'b0}};
                    state_s       = SLOT_STATE;
                    load_s        = 1'b1;
                    load_val_s    = SLOT_LOAD;
                end
                BLANK: begin
                    if (tc_s) begin
                        state_s    = DRIVE;
                        load_s     = 1'b1;
                        load_val_s = DRV_LOAD;
                    end else begin
                        state_s = BLANK;
                    end
                end
                DRIVE: begin
                    if (tc_s) begin
                        if (idx_r == LAST_IDX) begin
                            idx_s         = {IW{1'b0}};
                            frame_start_s = 1'b1;
                        end else begin
                            idx_s = idx_r + {{(IW-1){1'b0}}, 1'b1};
                        end
                        state_s    = SLOT_STATE;
                        load_s     = 1'b1;
                        load_val_s = SLOT_LOAD;
                    end else begin
                        state_s = DRIVE;
                    end
                end
                default: begin
                    state_s    = IDLE;
                    idx_s      = {IW{1'b0}};
                    load_s     = 1'b1;
                    load_val_s = {CW{1'b0}};
                end
            endcase
        end
    end

    // Next shadow contents and next output values; outputs read the
    // post-snapshot shadow so a zero-blank frame start shows fresh data.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seg_sh_s[i] = frame_start_s ? seg_t'(segments_in[i]) : seg_sh_r[i];
            onehot_s[i] = (idx_s == IW'(i));
        end
        dp_sh_s = frame_start_s ? dp_in    : dp_sh_r;
        en_sh_s = frame_start_s ? digit_en : en_sh_r;
        seg_s   = SEG_OFF;
        dp_s    = 1'b1;
        sel_s   = DIG_OFF;
        if ((state_s == DRIVE) && en_sh_s[idx_s]) begin
            seg_s = seg_sh_s[idx_s];
            dp_s  = dp_sh_s[idx_s];
            if (DIG_ACTIVE_LOW != 0) begin
                sel_s = ~onehot_s;
            end else begin
                sel_s = onehot_s;
            end
        end else begin
            seg_s = SEG_OFF;
            dp_s  = 1'b1;
            sel_s = DIG_OFF;
        end
    end

    // State, shadow and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            idx_r   <= {IW{1'b0}};
            for (int i = 0; i < NUM_DIGITS; i++) begin
                seg_sh_r[i] <= SEG_OFF;
            end
            dp_sh_r <= {NUM_DIGITS{1'b1}};
            en_sh_r <= {NUM_DIGITS{1'b0}};
            seg_r   <= SEG_OFF;
            dp_r    <= 1'b1;
            sel_r   <= DIG_OFF;
            tick_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                seg_sh_r[i] <= seg_sh_s[i];
            end
            dp_sh_r <= dp_sh_s;
            en_sh_r <= en_sh_s;
            seg_r   <= seg_s;
            dp_r    <= dp_s;
            sel_r   <= sel_s;
            tick_r  <= frame_start_s;
        end
    end

    assign seg_out    = seg_r;
    assign dp_out     = dp_r;
    assign dig_sel    = sel_r;
    assign digit_idx  = idx_r;
    assign frame_tick = tick_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: an 8-digit active-low instance and a 1-digit zero-blank
// active-high instance, both checked against a slot/phase arithmetic model.
module tb_seg_scan_driver;

    localparam int N0 = 8, B0 = 2, D0 = 4;
    localparam int N1 = 1, B1 = 0, D1 = 3;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [7:0] sel;
        logic [2:0] idx;
        logic       tick;
    } obs_t;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;
    logic [6:0] seg_in [8];
    logic [7:0] dp_in  = 8'hFF;
    logic [7:0] den    = 8'hFF;
    logic [6:0] seg1_in [1];

    logic [6:0] seg0_o, seg1_o;
    logic       dp0_o, dp1_o, tick0_o, tick1_o;
    logic [7:0] sel0_o;
    logic [0:0] sel1_o, idx1_o;
    logic [2:0] idx0_o;

    obs_t q0[$];
    obs_t q1[$];
    int   vectors = 0;
    int   miscompares = 0;

    bit         act  [2];
    int         tcnt [2];
    logic [6:0] snap [2][8];
    logic [7:0] sdp  [2];
    logic [7:0] sen  [2];

    assign seg1_in[0] = seg_in[0];

    seg_scan_driver #(.NUM_DIGITS(N0), .DRIVE_CYCLES(D0), .BLANK_CYCLES(B0),
                      .DIG_ACTIVE_LOW(1)) u_dut0 (
        .clk(clk), .reset(reset), .enable(enable), .segments_in(seg_in),
        .dp_in(dp_in), .digit_en(den), .seg_out(seg0_o), .dp_out(dp0_o),
        .dig_sel(sel0_o), .digit_idx(idx0_o), .frame_tick(tick0_o));

    seg_scan_driver #(.NUM_DIGITS(N1), .DRIVE_CYCLES(D1), .BLANK_CYCLES(B1),
                      .DIG_ACTIVE_LOW(0)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable), .segments_in(seg1_in),
        .dp_in(dp_in[0]), .digit_en(den[0]), .seg_out(seg1_o), .dp_out(dp1_o),
        .dig_sel(sel1_o), .digit_idx(idx1_o), .frame_tick(tick1_o));

    always #5 clk = ~clk;

    // Expected outputs from time within the frame: slot = t/(B+D), the first B
    // clocks of each slot are dark, the rest show that slot's snapshot.
    function automatic obs_t predict(input int b, input int d, input bit a,
                                     input int t, input logic [6:0] ss [8],
                                     input logic [7:0] sd, input logic [7:0] se,
                                     input bit tk);
        obs_t o;
        int   slot;
        int   phase;
        o.seg = 7'h7F; o.dp = 1'b1; o.sel = 8'h00; o.idx = 3'd0; o.tick = tk;
        if (a) begin
            slot  = t / (b + d);
            phase = t % (b + d);
            o.idx = 3'(slot);
            if (phase >= b && se[slot]) begin
                o.seg = ss[slot];
                o.dp  = sd[slot];
                o.sel = 8'h01 << slot;
            end
        end
        return o;
    endfunction

    // Reference model: one prediction per DUT per rising edge.
    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                int         n, b, d;
                bit         tk;
                logic [6:0] cur [8];
                n  = (k == 0) ? N0 : N1;
                b  = (k == 0) ? B0 : B1;
                d  = (k == 0) ? D0 : D1;
                tk = 1'b0;
                if (reset) begin
                    act[k] = 1'b0; tcnt[k] = 0;
                    for (int j = 0; j < 8; j++) snap[k][j] = 7'h7F;
                    sdp[k] = 8'hFF; sen[k] = 8'h00;
                end else if (!enable) begin
                    act[k] = 1'b0; tcnt[k] = 0;
                end else begin
                    if (act[k]) tcnt[k] = tcnt[k] + 1;
                    if (!act[k] || tcnt[k] == n * (b + d)) begin
                        act[k] = 1'b1; tcnt[k] = 0; tk = 1'b1;
                        for (int j = 0; j < 8; j++) snap[k][j] = seg_in[j];
                        sdp[k] = dp_in; sen[k] = den;
                    end
                end
                for (int j = 0; j < 8; j++) cur[j] = snap[k][j];
                if (k == 0) q0.push_back(predict(b, d, act[k], tcnt[k], cur, sdp[k], sen[k], tk));
                else        q1.push_back(predict(b, d, act[k], tcnt[k], cur, sdp[k], sen[k], tk));
            end
        end
    end

    task automatic check_one(input int k);
        obs_t a, e;
        bit   have;
        if (k == 0) a = {seg0_o, dp0_o, ~sel0_o, idx0_o, tick0_o};
        else        a = {seg1_o, dp1_o, 7'b0000000, sel1_o, 2'b00, idx1_o, tick1_o};
        have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
        vectors++;
        if (!have) begin
            miscompares++;
            $display("FAIL dut%0d no_expectation actual=%h at %0t", k, a, $time);
        end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            if (a !== e) begin
                miscompares++;
                $display("FAIL dut%0d outputs at %0t: actual seg=%h dp=%b sel=%h idx=%0d tick=%b required seg=%h dp=%b sel=%h idx=%0d tick=%b",
                         k, $time, a.seg, a.dp, a.sel, a.idx, a.tick, e.seg, e.dp, e.sel, e.idx, e.tick);
            end
        end
    endtask

    // Monitor: compares both DUTs on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check_one(0);
            check_one(1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = tick0_o;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_tick_timeout actual=none required=pulse within 200 cycles");
        end
    endtask

    initial begin
        for (int j = 0; j < 8; j++) seg_in[j] = 7'($urandom);
        cyc(3);
        reset = 1'b0;
        cyc(3);
        seg_in[3] = 7'b0110000;
        dp_in[3]  = 1'b0;
        seg_in[0] = 7'b1111001;
        enable    = 1'b1;
        wait_tick();
        cyc(5 * (B0 + D0) + 2);
        seg_in[0] = 7'b0100100;
        cyc(60);
        den = 8'h0F;
        cyc(100);
        den = 8'hFF;
        wait_tick();
        cyc(2 * (B0 + D0) + 3);
        enable = 1'b0;
        cyc(1);
        enable = 1'b1;
        cyc(20);
        wait_tick();
        cyc(4);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(60);
        for (int r = 0; r < 30; r++) begin
            int sel;
            for (int j = 0; j < 8; j++) seg_in[j] = 7'($urandom);
            dp_in = 8'($urandom);
            den   = 8'($urandom);
            cyc($urandom_range(1, 70));
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                reset = 1'b1;
                cyc(1);
                reset = 1'b0;
            end else if (sel < 3) begin
                enable = 1'b0;
                cyc($urandom_range(1, 5));
                enable = 1'b1;
            end
        end
        cyc(10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Time-multiplexed scan driver for the board's 8-digit common-anode 7-segment display. It consumes the per-digit active-low segment patterns produced by the hex-decode stage (segments[8]) and drives one shared segment bus plus per-digit select lines. It lights one digit at a time, inserts a blanking gap between digits to prevent ghosting, and snapshots its inputs once per frame so a displayed value never tears mid-scan.

Parameters:
NUM_DIGITS, 8, number of digits scanned; range 1..8.
DRIVE_CYCLES, 50000, clocks each digit is lit per slot; must be >= 1.
BLANK_CYCLES, 500, clocks of all-off before each digit's drive phase; 0 removes the blank phase.
DIG_ACTIVE_LOW, 1, 1 means dig_sel bit = 0 selects a digit; 0 means active-high.

Ports:
clk  in  1  system clock; all logic is rising-edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  scan enable; low forces the display dark.
segments_in  in  7 x NUM_DIGITS (unpacked [NUM_DIGITS])  active-low patterns from the hex decoder; index 0 is the rightmost digit.
dp_in  in  NUM_DIGITS  active-low decimal point per digit.
digit_en  in  NUM_DIGITS  1 = digit shown; 0 = slot kept but the digit stays dark (leading-zero blanking).
seg_out  out  7  active-low segment bus.
dp_out  out  1  active-low decimal point.
dig_sel  out  NUM_DIGITS  digit select; at most one digit active; polarity set by DIG_ACTIVE_LOW.
digit_idx  out  $clog2(NUM_DIGITS) (min 1)  index of the current slot.
frame_tick  out  1  one-cycle pulse at each frame start.

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is synchronous and active-high.
- All outputs are registered. seg_out, dp_out and dig_sel update on the same edge, so segments never change while a digit is selected.
- Reset values: state=IDLE, digit_idx=0, counter=0, seg_out=7'h7F, dp_out=1, dig_sel=all inactive, frame_tick=0. Shadow segments are set to 7'h7F, shadow dp to 1, and shadow digit_en to 0.
- States are IDLE, BLANK and DRIVE.
- IDLE: outputs dark. On the first edge with enable=1, perform the frame start, then go to BLANK.
- Frame start happens on the edge that enters BLANK for slot 0. On that edge:
  - latch segments_in, dp_in and digit_en into the shadow registers;
  - frame_tick=1 for exactly that cycle;
  - digit_idx=0 and counter=0.
- BLANK: hold dig_sel inactive, seg_out=7'h7F and dp_out=1 for BLANK_CYCLES cycles, then go to DRIVE. If BLANK_CYCLES=0, enter DRIVE directly and skip BLANK.
- DRIVE: for DRIVE_CYCLES cycles:
  - seg_out = shadow_seg[digit_idx] and dp_out = shadow_dp[digit_idx];
  - dig_sel is one-hot on digit_idx, but only if shadow_en[digit_idx]=1; otherwise dig_sel stays inactive and seg_out=7'h7F.
- End of DRIVE:
  - if digit_idx = NUM_DIGITS-1: wrap to 0, perform a frame start, go to BLANK;
  - otherwise increment digit_idx and go to BLANK.
- Frame length is NUM_DIGITS*(BLANK_CYCLES+DRIVE_CYCLES) clocks, with exactly one frame_tick per frame.
- Input latency: a segments_in change becomes visible only after the next frame start. Changes mid-frame are ignored until then.
- enable falling: on the next edge go to IDLE, force outputs dark, and set digit_idx=0 and counter=0. No partial slot completes.
- enable rising: restarts at slot 0 with a fresh snapshot and a frame_tick.
- reset is asserted mid-slot: on the next edge, apply the reset values. reset has priority over enable.
- NUM_DIGITS=1: every slot is a frame start, so frame_tick pulses every BLANK_CYCLES+DRIVE_CYCLES clocks.
- The counter is wide enough for max(DRIVE_CYCLES, BLANK_CYCLES)-1 and never overflows.

Decomposition:
- Package seg_pkg holds:
  - typedef seg_t (logic[6:0], active-low);
  - constant SEG_OFF=7'h7F;
  - the state enum scan_state_t {IDLE, BLANK, DRIVE}.
- The hex-decode patterns also move to seg_pkg, so the decoder and this driver share seg_t.
- One natural sub-module, seg_scan_timer: a loadable down-counter with a terminal-count output, parameterised by width. The FSM, the shadow registers and the output registers stay in seg_scan_driver.

Test Plan:
- Cadence check (NUM_DIGITS=8, BLANK=2, DRIVE=4), enable=1 after reset release -> frame_tick every 48 clocks. Each slot shows 2 dark clocks, then dig_sel active on digit 0..7 in order for 4 clocks each. dig_sel is never multi-hot.
- Pattern check: segments_in[3]=7'b0110000 ("3"), dp_in[3]=0 -> during slot 3 DRIVE, seg_out=7'b0110000 and dp_out=0. During BLANK, seg_out=7'h7F.
- Tearing check: change segments_in[0] from "1" (7'b1111001) to "2" (7'b0100100) during slot 5 -> the remaining slots are unchanged. The "2" appears in slot 0 only after the next frame_tick.
- Blanking check: digit_en=8'b0000_1111 -> dig_sel stays inactive in slots 4..7, yet the frame is still 48 clocks.
- Control check: drop enable during slot 2 DRIVE -> the next cycle is dark with digit_idx=0. Re-raise enable -> frame_tick on the same edge, slot 0 restarts. Assert reset mid-DRIVE -> reset values on the next edge.
- Edge check: BLANK_CYCLES=0 and NUM_DIGITS=1 -> no dark gap, and frame_tick every DRIVE_CYCLES clocks.
